// File: rtl/vend_pkg.sv
// Shared vending definitions: dispense FSM state encoding and default phase lengths,
// also used by the coin/credit FSM.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOTOR  = 3'd1,
    S_CHANGE = 3'd2,
    S_DOOR   = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } vend_state_e;

  localparam int MOTOR_CYC_DEF  = 8;
  localparam int CHANGE_CYC_DEF = 4;
  localparam int DOOR_CYC_DEF   = 50_000_000;
  localparam int CW_DEF         = 26;

endpackage

// File: rtl/vend_cycle_timer.sv
// Loadable down-counter that stops at zero; zero flags the last cycle of a phase.
module vend_cycle_timer #(
  parameter int CW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - CW'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: motor, optional change hopper, door unlock, then a done pulse.
// A jam during the motor phase latches a fault that only reset clears.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYC  = MOTOR_CYC_DEF,
  parameter int CHANGE_CYC = CHANGE_CYC_DEF,
  parameter int DOOR_CYC   = DOOR_CYC_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vend_req,
  input  logic vend_change,
  input  logic jam,
  output logic vend_ack,
  output logic motor_en,
  output logic change_en,
  output logic door_unlock,
  output logic busy,
  output logic done,
  output logic fault
);

  localparam logic [CW-1:0] MOTOR_LD  = CW'(MOTOR_CYC - 1);
  localparam logic [CW-1:0] CHANGE_LD = CW'(CHANGE_CYC - 1);
  localparam logic [CW-1:0] DOOR_LD   = CW'(DOOR_CYC - 1);

  vend_state_e   state, state_nx;
  logic          chg_q;
  logic          tmr_load, tmr_zero;
  logic [CW-1:0] tmr_val;
  logic          motor_d, change_d, door_d, busy_d, done_d, fault_d;

  // Held-off during reset so a request held across reset release is acked exactly once.
  assign vend_ack = (state == S_IDLE) && vend_req && !rst;

  vend_cycle_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      chg_q       <= 1'b0;
      motor_en    <= 1'b0;
      change_en   <= 1'b0;
      door_unlock <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      if (vend_ack) chg_q <= vend_change;
      motor_en    <= motor_d;
      change_en   <= change_d;
      door_unlock <= door_d;
      busy        <= busy_d;
      done        <= done_d;
      fault       <= fault_d;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_IDLE: begin
        if (vend_ack) begin
          state_nx = S_MOTOR;
          tmr_load = 1'b1;
          tmr_val  = MOTOR_LD;
        end
      end
      S_MOTOR: begin
        // Jam beats the normal exit, even on the final motor cycle.
        if (jam) begin
          state_nx = S_FAULT;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          if (chg_q) begin
            state_nx = S_CHANGE;
            tmr_val  = CHANGE_LD;
          end else begin
            state_nx = S_DOOR;
            tmr_val  = DOOR_LD;
          end
        end
      end
      S_CHANGE: begin
        if (tmr_zero) begin
          state_nx = S_DOOR;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LD;
        end
      end
      S_DOOR:  if (tmr_zero) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they align with the state.
  always_comb begin
    motor_d  = (state_nx == S_MOTOR);
    change_d = (state_nx == S_CHANGE);
    door_d   = (state_nx == S_DOOR);
    done_d   = (state_nx == S_DONE);
    fault_d  = (state_nx == S_FAULT);
    busy_d   = (state_nx != S_IDLE);
  end

endmodule
